// File: rtl/rv_mem_arbiter.sv
// Two-requester (IF / LS) arbiter for the shared single-port synchronous memory.
// Optional grant/conflict statistics counters are enabled by defining ARB_STATS_EN.
module rv_mem_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [DW/8-1:0] ls_be,
    input  logic [AW-1:0]   ls_addr,
    input  logic [DW-1:0]   ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [DW-1:0]   ls_rdata,
    output logic            mem_ce,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]     if_gnt_cnt,
    output logic [31:0]     ls_gnt_cnt,
    output logic [31:0]     conflict_cnt
`endif
);

    logic [3:0] starve_q, starve_d;
    logic       pend_if_q, pend_if_d;
    logic       pend_ls_q, pend_ls_d;
    logic       if_win;

    // IF wins when it is alone, or when it has been denied long enough.
    always_comb begin
        if_win = if_req && (!ls_req || (starve_q >= 4'(STARVE_MAX)));
        if_gnt = rst && if_win;
        ls_gnt = rst && ls_req && !if_win;
    end

    always_comb begin
        mem_ce    = if_gnt || ls_gnt;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_be   = '1;
            mem_addr = if_addr;
        end else if (ls_gnt) begin
            mem_we    = ls_we;
            mem_be    = ls_be;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end
    end

    always_comb begin
        starve_d = '0;
        if (if_req && !if_gnt)
            starve_d = (starve_q == 4'hF) ? 4'hF : starve_q + 4'd1;
        pend_if_d = if_gnt;
        pend_ls_d = ls_gnt && !ls_we;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q  <= '0;
            pend_if_q <= 1'b0;
            pend_ls_q <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            pend_if_q <= pend_if_d;
            pend_ls_q <= pend_ls_d;
        end
    end

    always_comb begin
        if_rvalid = pend_if_q;
        ls_rvalid = pend_ls_q;
        if_rdata  = pend_if_q ? mem_rdata : '0;
        ls_rdata  = pend_ls_q ? mem_rdata : '0;
    end

`ifdef ARB_STATS_EN
    logic [31:0] if_gnt_cnt_q, if_gnt_cnt_d;
    logic [31:0] ls_gnt_cnt_q, ls_gnt_cnt_d;
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        if_gnt_cnt_d   = if_gnt_cnt_q + 32'(if_gnt);
        ls_gnt_cnt_d   = ls_gnt_cnt_q + 32'(ls_gnt);
        conflict_cnt_d = conflict_cnt_q + 32'(if_req && ls_req);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_gnt_cnt_q   <= '0;
            ls_gnt_cnt_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if_gnt_cnt_q   <= if_gnt_cnt_d;
            ls_gnt_cnt_q   <= ls_gnt_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign if_gnt_cnt   = if_gnt_cnt_q;
    assign ls_gnt_cnt   = ls_gnt_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Self-checking bench for rv_mem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model (ARB_STATS_EN aware).
module tb_rv_mem_arbiter;

    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_ce, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_STATS_EN
    logic [31:0] if_gnt_cnt, ls_gnt_cnt, conflict_cnt;
`endif

    rv_mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
        .ls_rdata(ls_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
        ,
        .if_gnt_cnt(if_gnt_cnt), .ls_gnt_cnt(ls_gnt_cnt), .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who is owed a read response next cycle, and how many
    // consecutive cycles IF has been turned away.
    bit          m_resp_if, m_resp_ls;
    int unsigned m_denied;
`ifdef ARB_STATS_EN
    int unsigned m_if_cnt, m_ls_cnt, m_conf_cnt;
`endif

    // Drive one cycle of inputs at negedge, check all outputs, advance the model.
    task automatic step(input logic r, input logic ir, input logic [31:0] ia,
                        input logic lr, input logic lw, input logic [3:0] lb,
                        input logic [31:0] la, input logic [31:0] lwd,
                        input logic [31:0] rd);
        bit e_if, e_ls, e_ce, e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wd;
        @(negedge clk);
        rst = r; if_req = ir; if_addr = ia; ls_req = lr; ls_we = lw;
        ls_be = lb; ls_addr = la; ls_wdata = lwd; mem_rdata = rd;
        #1;
        if (!r) begin
            m_resp_if = 0; m_resp_ls = 0; m_denied = 0;
`ifdef ARB_STATS_EN
            m_if_cnt = 0; m_ls_cnt = 0; m_conf_cnt = 0;
`endif
            e_if = 0; e_ls = 0;
        end else begin
            e_if = ir && (!lr || m_denied >= STARVE_MAX);
            e_ls = lr && !e_if;
        end
        e_ce = e_if || e_ls;
        e_we = e_ls && lw;
        e_be = e_if ? 4'hF : (e_ls ? lb : 4'h0);
        e_addr = e_if ? ia : (e_ls ? la : 32'h0);
        e_wd = e_ls ? lwd : 32'h0;
        check_eq("if_gnt", 64'(if_gnt), 64'(e_if));
        check_eq("ls_gnt", 64'(ls_gnt), 64'(e_ls));
        check_eq("mem_ce", 64'(mem_ce), 64'(e_ce));
        check_eq("mem_we", 64'(mem_we), 64'(e_we));
        check_eq("mem_be", 64'(mem_be), 64'(e_be));
        check_eq("mem_addr", 64'(mem_addr), 64'(e_addr));
        check_eq("mem_wdata", 64'(mem_wdata), 64'(e_wd));
        check_eq("if_rvalid", 64'(if_rvalid), 64'(m_resp_if));
        check_eq("ls_rvalid", 64'(ls_rvalid), 64'(m_resp_ls));
        check_eq("if_rdata", 64'(if_rdata), m_resp_if ? 64'(rd) : 64'h0);
        check_eq("ls_rdata", 64'(ls_rdata), m_resp_ls ? 64'(rd) : 64'h0);
`ifdef ARB_STATS_EN
        check_eq("if_gnt_cnt", 64'(if_gnt_cnt), 64'(m_if_cnt));
        check_eq("ls_gnt_cnt", 64'(ls_gnt_cnt), 64'(m_ls_cnt));
        check_eq("conflict_cnt", 64'(conflict_cnt), 64'(m_conf_cnt));
`endif
        if (r) begin
            m_resp_if = e_if;
            m_resp_ls = e_ls && !lw;
            m_denied  = (ir && !e_if) ? ((m_denied < 15) ? m_denied + 1 : 15) : 0;
`ifdef ARB_STATS_EN
            m_if_cnt   += int'(e_if);
            m_ls_cnt   += int'(e_ls);
            m_conf_cnt += int'(ir && lr);
`endif
        end
    endtask

    task automatic idle(input logic r, input logic [31:0] rd);
        step(r, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, rd);
    endtask

    logic        h_if, h_ls, h_we;
    logic [31:0] h_ia, h_la, h_wd;
    logic [3:0]  h_be;

    initial begin
        rst = 0; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_be = 0;
        ls_addr = 0; ls_wdata = 0; mem_rdata = 0;
        m_resp_if = 0; m_resp_ls = 0; m_denied = 0;
`ifdef ARB_STATS_EN
        m_if_cnt = 0; m_ls_cnt = 0; m_conf_cnt = 0;
`endif

        // Reset with requests asserted: everything must stay low.
        step(0, 1, 32'h40, 1, 0, 4'hF, 32'h80, 32'h1, 32'hFFFF_FFFF);
        check_eq("rst_mem_ce", 64'(mem_ce), 64'h0);
        idle(0, 32'h0);
        idle(1, 32'h0);

        // IF-only read of address 0, response 0x93 one cycle later.
        step(1, 1, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        check_eq("if_only_gnt", 64'(if_gnt), 64'h1);
        idle(1, 32'h0000_0093);
        check_eq("if_only_rdata", 64'(if_rdata), 64'h93);
        check_eq("if_only_ls_rvalid", 64'(ls_rvalid), 64'h0);

        // LS write: no response on either port afterwards.
        step(1, 0, 32'h0, 1, 1, 4'b0011, 32'h100, 32'hDEAD_BEEF, 32'h0);
        check_eq("ls_wr_mem_we", 64'(mem_we), 64'h1);
        check_eq("ls_wr_mem_be", 64'(mem_be), 64'h3);
        idle(1, 32'h5555_5555);
        check_eq("ls_wr_no_rvalid", 64'({if_rvalid, ls_rvalid}), 64'h0);

        // Continuous contention: LS x4, then IF.
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 32'h200, 1, 0, 4'hF, 32'h300 + 32'(i), 32'h0, 32'h1000 + 32'(i));
            check_eq("starve_seq", 64'({if_gnt, ls_gnt}), (i == 4) ? 64'h2 : 64'h1);
        end
        idle(1, 32'h2000);
        check_eq("starve_if_resp", 64'(if_rvalid), 64'h1);

        // Alternating IF, LS, IF: no cross-steering.
        step(1, 1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        step(1, 0, 32'h0, 1, 0, 4'hF, 32'h20, 32'h0, 32'h11);
        check_eq("alt_if_rdata", 64'(if_rdata), 64'h11);
        step(1, 1, 32'h30, 0, 0, 4'h0, 32'h0, 32'h0, 32'h22);
        check_eq("alt_ls_rdata", 64'(ls_rdata), 64'h22);
        idle(1, 32'h33);
        check_eq("alt_if_rdata2", 64'(if_rdata), 64'h33);

        // Reset right after an IF grant discards the response.
        step(1, 1, 32'h44, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        idle(0, 32'hAAAA_AAAA);
        check_eq("rst_if_rvalid", 64'(if_rvalid), 64'h0);
        idle(1, 32'hBBBB_BBBB);
        check_eq("rst_rel_if_rvalid", 64'(if_rvalid), 64'h0);

`ifdef ARB_STATS_EN
        idle(0, 32'h0);
        idle(1, 32'h0);
        for (int i = 0; i < 10; i++)
            step(1, 1, 32'h0, 1, 0, 4'hF, 32'h4, 32'h0, 32'h0);
        idle(1, 32'h0);
        check_eq("stats_conflict", 64'(conflict_cnt), 64'd10);
        check_eq("stats_gnt_sum", 64'(if_gnt_cnt + ls_gnt_cnt), 64'd10);
        idle(0, 32'h0);
        check_eq("stats_rst", 64'({if_gnt_cnt, ls_gnt_cnt} | 64'(conflict_cnt)), 64'h0);
`endif

        // Random traffic; requesters hold their request until granted.
        h_if = 0; h_ls = 0; h_we = 0; h_ia = 0; h_la = 0; h_wd = 0; h_be = 0;
        for (int i = 0; i < 3000; i++) begin
            logic r;
            r = ($urandom_range(0, 99) != 0);
            if (!h_if) begin
                h_if = ($urandom_range(0, 2) != 0);
                h_ia = $urandom;
            end
            if (!h_ls) begin
                h_ls = ($urandom_range(0, 2) != 0);
                h_we = $urandom_range(0, 1);
                h_be = 4'($urandom);
                h_la = $urandom;
                h_wd = $urandom;
            end
            step(r, h_if, h_ia, h_ls, h_we, h_be, h_la, h_wd, $urandom);
            if (if_gnt) h_if = 0;
            if (ls_gnt) h_ls = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
- Two-requester arbiter that shares the SoC's single-port synchronous memory between the core's instruction-fetch port (IF) and load/store port (LS).
- Sits in rv_soc between rv_core and the memory instance.
- Fully pipelined: one memory access can be issued per cycle, and read data is steered back to the owning requester one cycle later.
- LS has priority by default; a starvation counter guarantees IF forward progress.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits (must be 32; byte enables are DW/8 wide).
- STARVE_MAX, 4, consecutive IF-request-denied cycles after which IF wins the next contention; range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- if_req  in  1  IF read request.
- if_addr  in  AW  IF word address.
- if_gnt  out  1  IF request accepted this cycle.
- if_rvalid  out  1  IF read data valid.
- if_rdata  out  DW  IF read data.
- ls_req  in  1  LS request.
- ls_we  in  1  1 = write, 0 = read.
- ls_be  in  DW/8  write byte enables.
- ls_addr  in  AW  LS address.
- ls_wdata  in  DW  LS write data.
- ls_gnt  out  1  LS request accepted.
- ls_rvalid  out  1  LS read data valid; asserted for reads only.
- ls_rdata  out  DW  LS read data.
- mem_ce  out  1  memory access enable.
- mem_we  out  1  memory write.
- mem_be  out  DW/8  memory byte enables.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid the cycle after a read with mem_ce=1.

Behaviour:
- Grant logic is combinational within a cycle.
- At most one of if_gnt and ls_gnt is 1 in any cycle.
- A grant is given only to an asserted request.
- Requesters hold req and address stable until they see gnt.
- Only IF requesting: grant IF.
- Only LS requesting: grant LS.
- Both requesting: grant LS, unless starve_cnt >= STARVE_MAX, in which case grant IF.
- starve_cnt (4-bit register):
  - Increments, saturating at 15, each cycle that if_req=1 and if_gnt=0.
  - Clears to 0 on any cycle with if_gnt=1, or with if_req=0.
- mem_* outputs are combinational from the granted port:
  - mem_ce=1 iff a grant is given.
  - IF grant: mem_we=0, mem_be=all ones, mem_addr=if_addr, mem_wdata=0.
  - LS grant: mem_we=ls_we, mem_be=ls_be, mem_addr=ls_addr, mem_wdata=ls_wdata.
  - No grant: mem_ce=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- Response tracking registers, updated every clock:
  - pend_if <= if_gnt.
  - pend_ls <= ls_gnt & ~ls_we.
- Read latency is exactly 1 cycle after the grant:
  - if_rvalid = pend_if, if_rdata = mem_rdata when pend_if, else 0.
  - ls_rvalid = pend_ls, ls_rdata = mem_rdata when pend_ls, else 0.
- Writes produce no rvalid.
- Back-to-back grants to the same or alternating ports are allowed every cycle; there are no bubbles.
- Reset, asynchronous, active when rst=0:
  - starve_cnt=0, pend_if=0, pend_ls=0.
  - All outputs are 0 while rst=0, including gnts and mem_ce (gnts are gated by rst).
  - Reset asserted mid-access discards any pending response; no rvalid follows reset release.
- Address alignment and bus errors are not checked; they are the core's responsibility.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined, adds output ports:
  - if_gnt_cnt (32): IF grants.
  - ls_gnt_cnt (32): LS grants.
  - conflict_cnt (32): cycles with both requests asserted.
- All three counters wrap at 2^32 and reset to 0 on rst=0.
- They let the testbench print arbitration statistics at the end of an ISA test.
- When undefined, these ports and registers do not exist, and the block's behaviour is otherwise identical.

Test Plan:
- IF-only read of addr 0x0 with mem returning 0x00000093 → if_gnt=1 in cycle 0; if_rvalid=1 and if_rdata=0x00000093 in cycle 1; ls_rvalid=0.
- LS write (addr 0x100, wdata 0xDEADBEEF, be 4'b0011), no IF request → mem_ce=1, mem_we=1, mem_be=4'b0011, mem_addr=0x100; no rvalid on either port afterwards.
- Continuous IF and LS read requests, STARVE_MAX=4:
  - Grants are LS,LS,LS,LS then IF.
  - starve_cnt returns to 0 after the IF grant.
  - Each rvalid appears exactly 1 cycle after its grant on the correct port.
- Alternating single-cycle grants IF, LS, IF with distinct mem_rdata 0x11, 0x22, 0x33 → if_rdata=0x11, ls_rdata=0x22, if_rdata=0x33 on consecutive cycles; no cross-steering.
- Assert rst=0 the cycle after an IF grant → if_rvalid stays 0 at and after reset release; all outputs are 0 during reset.
- With ARB_STATS_EN: 10 cycles of both requests asserted → conflict_cnt=10 and if_gnt_cnt+ls_gnt_cnt=10; counters clear on reset.
